dp_arbiter: RTL and testbench
=============================

# dp_arbiter

Round-robin arbiter and sequencer that shares one ALU/register-file datapath among N_REQ requesters. It accepts an operation request per requester and latches the winner's operands. It then drives the datapath's load, ALU-select, write-enable and address controls through a fixed five-state sequence, and returns the read-back result with a one-cycle acknowledge. It sits between the client blocks and the datapath, in place of a single-master controller.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width
- AW, 5, register-file address width
- ar_clk  in  1  clock, all state on rising edge
- ar_reset  in  1  synchronous, active-high reset
- ar_req  in  N_REQ  per-requester request level
- ar_op  in  3*N_REQ  ALU select, requester i at [3i+2:3i]
- ar_opa / ar_opb  in  WIDTH*N_REQ  operands, requester i at [WIDTH*i +: WIDTH]
- ar_waddr  in  AW*N_REQ  destination register, requester i at [AW*i +: AW]
- ar_grant  out  N_REQ  one-hot, current owner
- ar_ack  out  N_REQ  one-cycle completion pulse to owner
- ar_result  out  WIDTH  registered read-back value
- ar_carry / ar_ovf  out  1  registered datapath flags
- ar_dp_inp1 / ar_dp_inp2  out  WIDTH  datapath operands
- ar_dp_load1 / ar_dp_load2  out  1  operand register loads
- ar_dp_sel_alu  out  3  ALU operation
- ar_dp_ReadWriteEn  out  1  register-file write enable
- ar_dp_WriteAddress / ar_dp_ReadAddress  out  AW  register-file addresses
- ar_dp_read  in  WIDTH  register-file read data
- ar_dp_carryout / ar_dp_overflow  in  1  ALU flags

## Operation
- States: IDLE, LOAD1, LOAD2, EXEC, READ, DONE.
- IDLE with any ar_req bit set:
  - Pick the first set bit at or after pointer ptr, wrapping modulo N_REQ.
  - Latch that requester's op/opa/opb/waddr into internal registers.
  - Set ar_grant to the winner and go to LOAD1.
- IDLE with no request: stay in IDLE with all outputs 0.
- LOAD1: ar_dp_inp1=opa, ar_dp_load1=1.
- LOAD2: ar_dp_inp2=opb, ar_dp_load2=1.
- EXEC: ar_dp_sel_alu=op, ar_dp_WriteAddress=waddr, ar_dp_ReadWriteEn=1. Flags are captured into ar_carry/ar_ovf on the exiting edge.
- READ: ar_dp_ReadWriteEn=0, ar_dp_ReadAddress=waddr. ar_dp_read is captured into ar_result on the exiting edge.
- DONE: ar_ack[winner]=1. On the exiting edge, ptr = (winner+1) mod N_REQ and ar_grant=0, then go to IDLE.
- Control outputs not listed for a state are 0. Operand and address outputs hold their last value.
- Operands are latched at the grant edge, so a requester may change its inputs after ar_grant rises.
- A requester must hold ar_req until ar_ack. Deasserting it mid-service does not abort the operation.
- A requester still asserting ar_req after ar_ack competes again from IDLE.
- ar_result, ar_carry and ar_ovf hold their value until the next READ/EXEC capture.

## Timing
- Reset value: all outputs 0, state IDLE, ptr 0, latched operands 0.
- Reset asserted in any state returns to IDLE on the next edge with no ack issued.
- ar_req sampled high in IDLE at edge k:
  - ar_grant is valid after edge k.
  - ar_ack is high from edge k+5 to edge k+6.
  - ar_result is valid from edge k+5.
- Throughput is one operation per 6 cycles. IDLE always costs one cycle between operations.
- Simultaneous requests are served in round-robin order. There is no starvation: worst-case wait is (N_REQ-1)*6 cycles plus the current operation.

## Configuration
- ARB_FIXED_PRIO_EN defined: ptr is held at 0, so the lowest-index active requester always wins.
- ARB_FIXED_PRIO_EN undefined (default): round-robin as described.
- No other behaviour differs between the two builds.

## Test plan
- Single request: req[0], op=ADD, opa=100, opb=27, waddr=1 -> grant=0001 after edge k, ack[0] at k+5, ar_result=127.
- Simultaneous requests: req=1111 held continuously -> acks in order 0,1,2,3,0, 6 cycles apart.
- Operand change after grant: req[2] with opa=5, opb=3 (SUB), then opa changed to 99 after grant -> ar_result=2.
- Reset in EXEC: ar_reset at EXEC -> next cycle IDLE, all outputs 0, no ack, ptr=0.
- Early drop: req[1] deasserted during LOAD2 -> operation completes and ack[1] still pulses.
- Fixed priority: build with ARB_FIXED_PRIO_EN and req=0110 held -> requester 1 served repeatedly, requester 2 never granted.

Source files
------------

// File: rtl/dp_arbiter_if.sv
// Requester and datapath signal bundle for dp_arbiter.
// slave is the arbiter side; master is the client/datapath side.
interface dp_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic [N_REQ-1:0]       ar_req;
  logic [3*N_REQ-1:0]     ar_op;
  logic [WIDTH*N_REQ-1:0] ar_opa;
  logic [WIDTH*N_REQ-1:0] ar_opb;
  logic [AW*N_REQ-1:0]    ar_waddr;
  logic [N_REQ-1:0]       ar_grant;
  logic [N_REQ-1:0]       ar_ack;
  logic [WIDTH-1:0]       ar_result;
  logic                   ar_carry;
  logic                   ar_ovf;
  logic [WIDTH-1:0]       ar_dp_inp1;
  logic [WIDTH-1:0]       ar_dp_inp2;
  logic                   ar_dp_load1;
  logic                   ar_dp_load2;
  logic [2:0]             ar_dp_sel_alu;
  logic                   ar_dp_ReadWriteEn;
  logic [AW-1:0]          ar_dp_WriteAddress;
  logic [AW-1:0]          ar_dp_ReadAddress;
  logic [WIDTH-1:0]       ar_dp_read;
  logic                   ar_dp_carryout;
  logic                   ar_dp_overflow;

  modport slave (
    input  ar_req, ar_op, ar_opa, ar_opb, ar_waddr,
           ar_dp_read, ar_dp_carryout, ar_dp_overflow,
    output ar_grant, ar_ack, ar_result, ar_carry, ar_ovf,
           ar_dp_inp1, ar_dp_inp2, ar_dp_load1, ar_dp_load2, ar_dp_sel_alu,
           ar_dp_ReadWriteEn, ar_dp_WriteAddress, ar_dp_ReadAddress
  );

  modport master (
    output ar_req, ar_op, ar_opa, ar_opb, ar_waddr,
           ar_dp_read, ar_dp_carryout, ar_dp_overflow,
    input  ar_grant, ar_ack, ar_result, ar_carry, ar_ovf,
           ar_dp_inp1, ar_dp_inp2, ar_dp_load1, ar_dp_load2, ar_dp_sel_alu,
           ar_dp_ReadWriteEn, ar_dp_WriteAddress, ar_dp_ReadAddress
  );
endinterface

// File: rtl/dp_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU/register-file datapath.
// Define ARB_FIXED_PRIO_EN to pin the pointer at 0 (lowest index always wins).
//
// state | meaning
// IDLE  | arbitrate, latch winner operands, raise grant
// LOAD1 | drive operand A and its load strobe
// LOAD2 | drive operand B and its load strobe
// EXEC  | drive ALU select, write address, write enable
// READ  | drive read address, capture ALU flags
// DONE  | capture read data, pulse ack, advance pointer
module dp_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input logic         ar_clk,
  input logic         ar_reset,
  dp_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, LOAD1, LOAD2, EXEC, READ, DONE} state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_nxt;
  logic [PW-1:0]    win_idx;
  logic             found;
  logic [N_REQ-1:0] win_onehot;
  logic [2:0]       win_op, op_q;
  logic [WIDTH-1:0] win_opa, win_opb, opa_q, opb_q;
  logic [AW-1:0]    win_waddr, waddr_q;

  // First pass looks at or above the pointer, second pass wraps to the lowest index.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.ar_req[i] && (PW'(i) >= ptr)) begin
        found   = 1'b1;
        win_idx = PW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.ar_req[i]) begin
        found   = 1'b1;
        win_idx = PW'(i);
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    win_op     = '0;
    win_opa    = '0;
    win_opb    = '0;
    win_waddr  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PW'(i) == win_idx) begin
        win_onehot[i] = 1'b1;
        win_op        = bus.ar_op[3*i +: 3];
        win_opa       = bus.ar_opa[WIDTH*i +: WIDTH];
        win_opb       = bus.ar_opb[WIDTH*i +: WIDTH];
        win_waddr     = bus.ar_waddr[AW*i +: AW];
      end
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign ptr_nxt = '0;
`else
  always_comb begin
    ptr_nxt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.ar_grant[i]) ptr_nxt = (i == N_REQ - 1) ? '0 : PW'(i + 1);
    end
  end
`endif

  // Outputs are registered from the current state, so each phase is visible
  // for the cycle after the state is entered.
  always_ff @(posedge ar_clk) begin
    if (ar_reset) begin
      state                  <= IDLE;
      ptr                    <= '0;
      op_q                   <= '0;
      opa_q                  <= '0;
      opb_q                  <= '0;
      waddr_q                <= '0;
      bus.ar_grant           <= '0;
      bus.ar_ack             <= '0;
      bus.ar_result          <= '0;
      bus.ar_carry           <= 1'b0;
      bus.ar_ovf             <= 1'b0;
      bus.ar_dp_inp1         <= '0;
      bus.ar_dp_inp2         <= '0;
      bus.ar_dp_load1        <= 1'b0;
      bus.ar_dp_load2        <= 1'b0;
      bus.ar_dp_sel_alu      <= '0;
      bus.ar_dp_ReadWriteEn  <= 1'b0;
      bus.ar_dp_WriteAddress <= '0;
      bus.ar_dp_ReadAddress  <= '0;
    end else begin
      bus.ar_ack            <= '0;
      bus.ar_dp_load1       <= 1'b0;
      bus.ar_dp_load2       <= 1'b0;
      bus.ar_dp_sel_alu     <= '0;
      bus.ar_dp_ReadWriteEn <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.ar_req) begin
            op_q         <= win_op;
            opa_q        <= win_opa;
            opb_q        <= win_opb;
            waddr_q      <= win_waddr;
            bus.ar_grant <= win_onehot;
            state        <= LOAD1;
          end
        end
        LOAD1: begin
          bus.ar_dp_inp1  <= opa_q;
          bus.ar_dp_load1 <= 1'b1;
          state           <= LOAD2;
        end
        LOAD2: begin
          bus.ar_dp_inp2  <= opb_q;
          bus.ar_dp_load2 <= 1'b1;
          state           <= EXEC;
        end
        EXEC: begin
          bus.ar_dp_sel_alu      <= op_q;
          bus.ar_dp_WriteAddress <= waddr_q;
          bus.ar_dp_ReadWriteEn  <= 1'b1;
          state                  <= READ;
        end
        READ: begin
          bus.ar_dp_ReadAddress <= waddr_q;
          bus.ar_carry          <= bus.ar_dp_carryout;
          bus.ar_ovf            <= bus.ar_dp_overflow;
          state                 <= DONE;
        end
        DONE: begin
          bus.ar_ack    <= bus.ar_grant;
          bus.ar_result <= bus.ar_dp_read;
          bus.ar_grant  <= '0;
          ptr           <= ptr_nxt;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_arbiter.sv
// Scoreboard bench for dp_arbiter with a behavioural ALU/register-file datapath.
// Expected results are pushed at grant time; a negedge monitor pops on every ack.
module tb_dp_arbiter;
  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int AW    = 5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd4;

  logic tb_clk   = 1'b0;
  logic ar_reset = 1'b1;
  always #5 tb_clk = ~tb_clk;

  dp_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .AW(AW)) bus ();

  dp_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .AW(AW)) dut (
    .ar_clk   (tb_clk),
    .ar_reset (ar_reset),
    .bus      (bus)
  );

  // Datapath: two operand registers, combinational ALU, register file.
  logic [WIDTH-1:0] r1, r2;
  logic [WIDTH-1:0] rf [0:(1<<AW)-1];
  logic [WIDTH:0]   alu_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;

  always_comb begin
    alu_full = '0;
    alu_v    = 1'b0;
    case (bus.ar_dp_sel_alu)
      OP_ADD:  alu_full = {1'b0, r1} + {1'b0, r2};
      OP_SUB:  alu_full = {1'b0, r1} - {1'b0, r2};
      OP_AND:  alu_full = {1'b0, r1 & r2};
      3'd3:    alu_full = {1'b0, r1 | r2};
      OP_XOR:  alu_full = {1'b0, r1 ^ r2};
      default: alu_full = '0;
    endcase
    alu_res = alu_full[WIDTH-1:0];
    if (bus.ar_dp_sel_alu == OP_ADD)
      alu_v = (r1[WIDTH-1] == r2[WIDTH-1]) && (alu_res[WIDTH-1] != r1[WIDTH-1]);
    else if (bus.ar_dp_sel_alu == OP_SUB)
      alu_v = (r1[WIDTH-1] != r2[WIDTH-1]) && (alu_res[WIDTH-1] != r1[WIDTH-1]);
  end

  assign bus.ar_dp_carryout = alu_full[WIDTH];
  assign bus.ar_dp_overflow = alu_v;
  assign bus.ar_dp_read     = rf[bus.ar_dp_ReadAddress];

  always @(posedge tb_clk) begin
    if (bus.ar_dp_load1) r1 <= bus.ar_dp_inp1;
    if (bus.ar_dp_load2) r2 <= bus.ar_dp_inp2;
    if (bus.ar_dp_ReadWriteEn) rf[bus.ar_dp_WriteAddress] <= alu_res;
  end

  int cyc = 0;
  always @(posedge tb_clk) cyc <= cyc + 1;

  typedef struct {
    logic [N_REQ-1:0] ack;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    int               at;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge tb_clk) begin
    if (bus.ar_ack != '0) begin : pop
      exp_t e;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack %b expected none (cycle %0d)", bus.ar_ack, cyc);
      end else begin
        e = sb_q.pop_front();
        check("ack_owner", 64'(bus.ar_ack), 64'(e.ack));
        check("ack_cycle", 64'(cyc), 64'(e.at));
        check("result", 64'(bus.ar_result), 64'(e.res));
        check("carry", 64'(bus.ar_carry), 64'(e.c));
        check("ovf", 64'(bus.ar_ovf), 64'(e.v));
      end
    end
  end

  task automatic set_slot(input int i, input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [AW-1:0] wa);
    bus.ar_op[3*i +: 3]           = op;
    bus.ar_opa[WIDTH*i +: WIDTH]  = a;
    bus.ar_opb[WIDTH*i +: WIDTH]  = b;
    bus.ar_waddr[AW*i +: AW]      = wa;
  endtask

  task automatic push_exp(input int i, input logic [WIDTH-1:0] r, input logic c,
                          input logic v, input int at);
    exp_t e;
    e.ack    = '0;
    e.ack[i] = 1'b1;
    e.res    = r;
    e.c      = c;
    e.v      = v;
    e.at     = at;
    sb_q.push_back(e);
  endtask

  // One isolated request; called at a negedge with the arbiter idle.
  task automatic serve(input int i, input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [AW-1:0] wa,
                       input logic [WIDTH-1:0] er, input logic ec, input logic ev,
                       input int drop_at, input logic [WIDTH-1:0] new_a);
    int k;
    logic [N_REQ-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    set_slot(i, op, a, b, wa);
    bus.ar_req[i] = 1'b1;
    @(negedge tb_clk);
    k = cyc;
    check("grant", 64'(bus.ar_grant), 64'(oh));
    push_exp(i, er, ec, ev, k + 5);
    bus.ar_opa[WIDTH*i +: WIDTH] = new_a;
    for (int j = 1; j <= 5; j++) begin
      @(negedge tb_clk);
      if (j == drop_at) bus.ar_req[i] = 1'b0;
      case (j)
        1: begin
          check("load1", 64'(bus.ar_dp_load1), 64'd1);
          check("inp1", 64'(bus.ar_dp_inp1), 64'(a));
        end
        2: begin
          check("load2", 64'(bus.ar_dp_load2), 64'd1);
          check("inp2", 64'(bus.ar_dp_inp2), 64'(b));
        end
        3: begin
          check("exec_we", 64'(bus.ar_dp_ReadWriteEn), 64'd1);
          check("exec_sel", 64'(bus.ar_dp_sel_alu), 64'(op));
          check("exec_waddr", 64'(bus.ar_dp_WriteAddress), 64'(wa));
        end
        4: begin
          check("read_we", 64'(bus.ar_dp_ReadWriteEn), 64'd0);
          check("read_raddr", 64'(bus.ar_dp_ReadAddress), 64'(wa));
        end
        default: check("grant_clear", 64'(bus.ar_grant), 64'd0);
      endcase
    end
    @(negedge tb_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int k0;
    int win [3];
    bus.ar_req   = '0;
    bus.ar_op    = '0;
    bus.ar_opa   = '0;
    bus.ar_opb   = '0;
    bus.ar_waddr = '0;

    repeat (3) @(negedge tb_clk);
    check("rst_grant", 64'(bus.ar_grant), 64'd0);
    check("rst_ack", 64'(bus.ar_ack), 64'd0);
    check("rst_result", 64'(bus.ar_result), 64'd0);
    check("rst_flags", 64'({bus.ar_carry, bus.ar_ovf}), 64'd0);
    check("rst_ctrl", 64'({bus.ar_dp_load1, bus.ar_dp_load2, bus.ar_dp_ReadWriteEn,
                           bus.ar_dp_sel_alu}), 64'd0);
    check("rst_inp", 64'({bus.ar_dp_inp1, bus.ar_dp_inp2}), 64'd0);
    ar_reset = 1'b0;
    @(negedge tb_clk);

    serve(0, OP_ADD, 32'd100, 32'd27, 5'd1, 32'd127, 1'b0, 1'b0, 5, 32'd100);
    serve(3, OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd2, 32'd0, 1'b1, 1'b0, 5, 32'hFFFF_FFFF);
    serve(1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd3, 32'h8000_0000, 1'b0, 1'b1, 5, 32'h7FFF_FFFF);
    serve(0, OP_SUB, 32'd3, 32'd5, 5'd31, 32'hFFFF_FFFE, 1'b1, 1'b0, 5, 32'd3);
    serve(2, OP_SUB, 32'd5, 32'd3, 5'd7, 32'd2, 1'b0, 1'b0, 5, 32'd99);
    serve(1, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd9, 32'h0F00_0F00, 1'b0, 1'b0, 1,
          32'hFF00_FF00);

    // Reset while in EXEC: everything clears and no ack follows.
    set_slot(1, OP_ADD, 32'd11, 32'd22, 5'd12);
    bus.ar_req[1] = 1'b1;
    @(negedge tb_clk);
    check("rx_grant", 64'(bus.ar_grant), 64'b0010);
    repeat (2) @(negedge tb_clk);
    ar_reset = 1'b1;
    @(negedge tb_clk);
    check("rx_grant0", 64'(bus.ar_grant), 64'd0);
    check("rx_result0", 64'(bus.ar_result), 64'd0);
    check("rx_ctrl0", 64'({bus.ar_dp_load1, bus.ar_dp_load2, bus.ar_dp_ReadWriteEn,
                           bus.ar_dp_sel_alu}), 64'd0);
    check("rx_inp0", 64'({bus.ar_dp_inp1, bus.ar_dp_inp2}), 64'd0);
    ar_reset      = 1'b0;
    bus.ar_req[1] = 1'b0;
    repeat (8) @(negedge tb_clk);
    check("rx_idle_grant", 64'(bus.ar_grant), 64'd0);

    // All four held: pointer restarts at 0, acks every 6 cycles.
    for (int i = 0; i < N_REQ; i++)
      set_slot(i, OP_ADD, 32'(10 * (i + 1)), 32'(i), 5'(4 + i));
    bus.ar_req = '1;
    @(negedge tb_clk);
    k0 = cyc;
    push_exp(0, 32'd10, 1'b0, 1'b0, k0 + 5);
    push_exp(1, 32'd21, 1'b0, 1'b0, k0 + 11);
    push_exp(2, 32'd32, 1'b0, 1'b0, k0 + 17);
    push_exp(3, 32'd43, 1'b0, 1'b0, k0 + 23);
    push_exp(0, 32'd10, 1'b0, 1'b0, k0 + 29);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) repeat (6) @(negedge tb_clk);
      check("rr_grant", 64'(bus.ar_grant), 64'(4'b0001 << (j % 4)));
    end
    repeat (5) @(negedge tb_clk);
    bus.ar_req = '0;
    repeat (2) @(negedge tb_clk);

    // req=0110 held; pointer now sits at 1.
`ifdef ARB_FIXED_PRIO_EN
    win = '{1, 1, 1};
`else
    win = '{1, 2, 1};
`endif
    set_slot(1, OP_SUB, 32'd50, 32'd8, 5'd10);
    set_slot(2, OP_XOR, 32'h0000_00F0, 32'h0000_000F, 5'd11);
    bus.ar_req = 4'b0110;
    @(negedge tb_clk);
    k0 = cyc;
    for (int j = 0; j < 3; j++)
      push_exp(win[j], (win[j] == 1) ? 32'd42 : 32'hFF, 1'b0, 1'b0, k0 + 5 + 6 * j);
    for (int j = 0; j < 3; j++) begin
      if (j > 0) repeat (6) @(negedge tb_clk);
      check("prio_grant", 64'(bus.ar_grant), 64'(4'b0001 << win[j]));
    end
    repeat (5) @(negedge tb_clk);
    bus.ar_req = '0;
    repeat (3) @(negedge tb_clk);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
